alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter SKIP_R0_WB, default 1; when 1, writeback to register 0 is suppressed.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request one operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 3 bits: operation code, sampled with start.
REQ-006 SHALL have ports rs1 and rs2, input, 5 bits each: source register indices, sampled with start.
REQ-007 SHALL have port rd, input, 5 bits: destination register index, sampled with start.
REQ-008 SHALL have port rb_sel, output, 5 bits: register bank select.
REQ-009 SHALL have port rb_wdata, output, 8 bits: register bank write data.
REQ-010 SHALL have port rb_write, output, 1 bit: register bank write enable.
REQ-011 SHALL have port rb_rdata, input, 8 bits: register bank read data, valid one clock after rb_sel is presented; index 0 reads 0.
REQ-012 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until writeback completes.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port result, output, 8 bits: last computed result, held until the next EXEC.
REQ-015 SHALL have ports flag_z and flag_c, output, 1 bit each: zero and carry/borrow of the last result.

Function
REQ-016 SHALL implement the states IDLE, RDA, RDB, EXEC and WB, with all outputs registered.
REQ-017 In IDLE with start=1, SHALL latch op, rs1, rs2 and rd, then go to RDA.
REQ-018 RDA: rb_sel=rs1; next state RDB.
REQ-019 RDB: rb_sel=rs2; operand A latched from rb_rdata at the end of the cycle; next state EXEC.
REQ-020 EXEC: operand B=rb_rdata; result, flag_z and flag_c updated at the end of the cycle; next state WB.
REQ-021 WB: rb_sel=rd, rb_wdata=result, rb_write=1; next state IDLE, with done=1 in the following cycle.
REQ-022 rb_write SHALL be 0 during WB when rd=0 and SKIP_R0_WB=1; done SHALL still pulse.
REQ-023 rb_write SHALL be 0 in all states other than WB.
REQ-024 rb_sel SHALL be 0 in IDLE.
REQ-025 Latency: start accepted at edge 0 -> rb_write high during cycle 4 -> done high during cycle 5, with busy already low.
REQ-026 start SHALL be ignored while busy=1; start in the cycle done=1 SHALL be accepted, giving back-to-back operations every 5 cycles.
REQ-027 op SHALL select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL A by 1, 110 SHR A by 1 (logical), 111 MOV A.
REQ-028 All arithmetic SHALL be mod 256.
REQ-029 ADD: flag_c = bit 8 of the 9-bit sum.
REQ-030 SUB: flag_c=1 when A<B (unsigned borrow).
REQ-031 SHL: flag_c=A[7]; SHR: flag_c=A[0].
REQ-032 Logic ops and MOV: flag_c=0.
REQ-033 flag_z SHALL be 1 when result==0.
REQ-034 When rs1==rs2, SHALL still perform two reads; A and B SHALL be equal.
REQ-035 When rd equals rs1 or rs2, writeback SHALL occur after both reads, so the operands are the pre-write values.

Reset
REQ-036 rst_n low SHALL immediately force state IDLE, rb_sel=0, rb_wdata=0, rb_write=0, busy=0, done=0, result=0, flag_z=0 and flag_c=0.
REQ-037 Reset during any state, including WB, SHALL abort the operation with no further write and no done pulse.
REQ-038 On reset release, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-039 ADD: r1=0xF0, r2=0x20, rd=3 -> WB writes 0x10 to 3, flag_c=1, flag_z=0, done at cycle 5.
REQ-040 SUB borrow: r4=0x05, r5=0x06, rd=6 -> result 0xFF, flag_c=1; SUB with r4=r5=0x05 -> result 0x00, flag_z=1, flag_c=0.
REQ-041 rd=0: XOR r1,r1 -> result 0x00, flag_z=1, rb_write never asserted, done pulses.
REQ-042 In-place: r7=0x81, SHL r7 -> r7 -> writes 0x02, flag_c=1; a following MOV r7 -> r8 copies 0x02.
REQ-043 start held high continuously -> an operation is accepted every 5 cycles; start pulses while busy produce no extra operations.
REQ-044 rst_n low during WB -> rb_write drops asynchronously, the target register is unchanged, no done pulse, and all outputs are 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: reads two operands from an external register bank,
// computes one 8-bit operation and writes the result back, one operation per 5 cycles.
module alu_sequencer #(
  parameter bit SKIP_R0_WB = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  output logic [4:0] rb_sel,
  output logic [7:0] rb_wdata,
  output logic       rb_write,
  input  logic [7:0] rb_rdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_c
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;

  state_t     state, state_nx;
  logic [2:0] op_q, op_nx;
  logic [4:0] rs2_q, rs2_nx;
  logic [4:0] rd_q, rd_nx;
  logic [7:0] a_q, a_nx;

  logic [4:0] rb_sel_nx;
  logic [7:0] rb_wdata_nx, result_nx;
  logic       rb_write_nx, busy_nx, done_nx, flag_z_nx, flag_c_nx;

  logic [8:0] sum9;
  logic [7:0] alu_res;
  logic       alu_c;

  // Every output is a flop; the comb block below computes the value it takes
  // for the cycle spent in the state being entered.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      rb_sel   <= '0;
      rb_wdata <= '0;
      rb_write <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      state    <= state_nx;
      op_q     <= op_nx;
      rs2_q    <= rs2_nx;
      rd_q     <= rd_nx;
      a_q      <= a_nx;
      rb_sel   <= rb_sel_nx;
      rb_wdata <= rb_wdata_nx;
      rb_write <= rb_write_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      result   <= result_nx;
      flag_z   <= flag_z_nx;
      flag_c   <= flag_c_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RDA;
      RDA:     state_nx = RDB;
      RDB:     state_nx = EXEC;
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand B is never stored: it arrives on rb_rdata during EXEC itself.
  assign sum9 = {1'b0, a_q} + {1'b0, rb_rdata};

  always_comb begin
    alu_res = a_q;
    alu_c   = 1'b0;
    unique case (op_q)
      3'b000: begin alu_res = sum9[7:0];      alu_c = sum9[8];        end
      3'b001: begin alu_res = a_q - rb_rdata; alu_c = a_q < rb_rdata; end
      3'b010: alu_res = a_q & rb_rdata;
      3'b011: alu_res = a_q | rb_rdata;
      3'b100: alu_res = a_q ^ rb_rdata;
      3'b101: begin alu_res = {a_q[6:0], 1'b0}; alu_c = a_q[7]; end
      3'b110: begin alu_res = {1'b0, a_q[7:1]}; alu_c = a_q[0]; end
      default: alu_res = a_q;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    op_nx       = op_q;
    rs2_nx      = rs2_q;
    rd_nx       = rd_q;
    a_nx        = a_q;
    rb_sel_nx   = rb_sel;
    rb_wdata_nx = rb_wdata;
    rb_write_nx = 1'b0;
    busy_nx     = busy;
    done_nx     = 1'b0;
    result_nx   = result;
    flag_z_nx   = flag_z;
    flag_c_nx   = flag_c;
    unique case (state)
      IDLE: if (start) begin
        op_nx     = op;
        rs2_nx    = rs2;
        rd_nx     = rd;
        rb_sel_nx = rs1;
        busy_nx   = 1'b1;
      end
      RDA:  rb_sel_nx = rs2_q;
      RDB:  a_nx = rb_rdata;
      EXEC: begin
        result_nx   = alu_res;
        flag_z_nx   = (alu_res == 8'h00);
        flag_c_nx   = alu_c;
        rb_sel_nx   = rd_q;
        rb_wdata_nx = alu_res;
        rb_write_nx = !(SKIP_R0_WB && rd_q == 5'd0);
      end
      WB: begin
        rb_sel_nx = '0;
        busy_nx   = 1'b0;
        done_nx   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural register bank plus an
// arithmetic reference model, directed cases and randomized operations.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [4:0] rs1, rs2, rd;
  logic [4:0] rb_sel;
  logic [7:0] rb_wdata;
  logic       rb_write;
  logic [7:0] rb_rdata;
  logic       busy, done;
  logic [7:0] result;
  logic       flag_z, flag_c;

  int checks   = 0;
  int failures = 0;

  logic [7:0] bank [32];
  logic [7:0] mdl  [32];
  logic       pre_we;
  logic [4:0] pre_idx;
  logic [7:0] pre_val;

  alu_sequencer #(.SKIP_R0_WB(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .rb_sel   (rb_sel),
    .rb_wdata (rb_wdata),
    .rb_write (rb_write),
    .rb_rdata (rb_rdata),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .flag_z   (flag_z),
    .flag_c   (flag_c)
  );

  always #5 clk = ~clk;

  // Register bank: synchronous write, read data one clock after the select.
  always @(posedge clk) begin
    if (pre_we) bank[pre_idx] <= pre_val;
    else if (rb_write) bank[rb_sel] <= rb_wdata;
    rb_rdata <= (rb_sel == 5'd0) ? 8'h00 : bank[rb_sel];
  end

  // Returns {zero, carry, result[7:0]} using plain integer arithmetic.
  function automatic logic [9:0] ref_alu(input int o, input int a, input int b);
    int r;
    bit c;
    c = 1'b0;
    case (o)
      0: begin r = (a + b) % 256; c = (a + b) > 255; end
      1: begin r = (a - b + 256) % 256; c = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 256; c = a >= 128; end
      6: begin r = a / 2; c = (a % 2) == 1; end
      default: r = a;
    endcase
    return {r == 0, c, r[7:0]};
  endfunction

  task automatic set_reg(input int i, input logic [7:0] v);
    pre_we = 1'b1; pre_idx = i[4:0]; pre_val = v;
    @(posedge clk);
    @(negedge clk);
    pre_we = 1'b0;
    mdl[i] = (i == 0) ? 8'h00 : v;
  endtask

  // Drives one operation from a negedge and checks every cycle through done.
  task automatic run_op(input logic [2:0] o, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input bit hold_start);
    logic [9:0] e;
    logic       exp_w;
    e = ref_alu(int'(o), int'(mdl[s1]), int'(mdl[s2]));
    exp_w = (d != 5'd0);
    start = 1'b1; op = o; rs1 = s1; rs2 = s2; rd = d;
    @(posedge clk);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    op = 3'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
    checks++;
    if ({busy, done, rb_write, rb_sel} !== {1'b1, 1'b0, 1'b0, s1}) begin
      failures++;
      $display("FAIL rda_cycle busy/done/wr/sel got=%b,%b,%b,%0d want=1,0,0,%0d",
               busy, done, rb_write, rb_sel, s1);
    end
    @(negedge clk);
    checks++;
    if ({busy, rb_write, rb_sel} !== {1'b1, 1'b0, s2}) begin
      failures++;
      $display("FAIL rdb_cycle busy/wr/sel got=%b,%b,%0d want=1,0,%0d", busy, rb_write, rb_sel, s2);
    end
    @(negedge clk);
    if (hold_start) start = 1'b0;
    checks++;
    if ({busy, rb_write, done} !== 3'b100) begin
      failures++;
      $display("FAIL exec_cycle busy/wr/done got=%b,%b,%b want=1,0,0", busy, rb_write, done);
    end
    @(negedge clk);
    checks++;
    if ({busy, rb_sel, rb_write, rb_wdata, result, flag_z, flag_c} !==
        {1'b1, d, exp_w, e[7:0], e[7:0], e[9], e[8]}) begin
      failures++;
      $display("FAIL wb_cycle op=%0d sel=%0d wr=%b wdata=%h res=%h z=%b c=%b want sel=%0d wr=%b data=%h z=%b c=%b",
               o, rb_sel, rb_write, rb_wdata, result, flag_z, flag_c, d, exp_w, e[7:0], e[9], e[8]);
    end
    if (exp_w) mdl[d] = e[7:0];
    @(negedge clk);
    checks++;
    if ({done, busy, rb_write, rb_sel, result, flag_z, flag_c} !==
        {1'b1, 1'b0, 1'b0, 5'd0, e[7:0], e[9], e[8]}) begin
      failures++;
      $display("FAIL done_cycle done=%b busy=%b wr=%b sel=%0d res=%h want done=1 busy=0 res=%h",
               done, busy, rb_write, rb_sel, result, e[7:0]);
    end
    checks++;
    if (bank[d] !== mdl[d]) begin
      failures++;
      $display("FAIL bank_write r%0d got=%h want=%h", d, bank[d], mdl[d]);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, result} !== {1'b0, 1'b0, e[7:0]}) begin
      failures++;
      $display("FAIL after_done done=%b busy=%b res=%h want 0,0,%h", done, busy, result, e[7:0]);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({rb_sel, rb_wdata, rb_write, busy, done, result, flag_z, flag_c} !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs sel=%0d wdata=%h wr=%b busy=%b done=%b res=%h z=%b c=%b want all 0",
               rb_sel, rb_wdata, rb_write, busy, done, result, flag_z, flag_c);
    end
  endtask

  task automatic test_directed();
    set_reg(1, 8'hF0); set_reg(2, 8'h20); set_reg(3, 8'h00);
    run_op(3'b000, 5'd1, 5'd2, 5'd3, 1'b0);
    checks++;
    if ({bank[3], flag_c, flag_z} !== {8'h10, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_carry r3=%h c=%b z=%b want 10,1,0", bank[3], flag_c, flag_z);
    end
    set_reg(4, 8'h05); set_reg(5, 8'h06);
    run_op(3'b001, 5'd4, 5'd5, 5'd6, 1'b0);
    checks++;
    if ({bank[6], flag_c} !== {8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL sub_borrow r6=%h c=%b want ff,1", bank[6], flag_c);
    end
    set_reg(5, 8'h05);
    run_op(3'b001, 5'd4, 5'd5, 5'd6, 1'b0);
    checks++;
    if ({bank[6], flag_z, flag_c} !== {8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub_equal r6=%h z=%b c=%b want 00,1,0", bank[6], flag_z, flag_c);
    end
    run_op(3'b100, 5'd1, 5'd1, 5'd0, 1'b0);
    set_reg(7, 8'h81);
    run_op(3'b101, 5'd7, 5'd7, 5'd7, 1'b0);
    checks++;
    if ({bank[7], flag_c} !== {8'h02, 1'b1}) begin
      failures++;
      $display("FAIL shl_inplace r7=%h c=%b want 02,1", bank[7], flag_c);
    end
    run_op(3'b111, 5'd7, 5'd3, 5'd8, 1'b0);
    checks++;
    if (bank[8] !== 8'h02) begin
      failures++;
      $display("FAIL mov_copy r8=%h want 02", bank[8]);
    end
  endtask

  task automatic test_ignore_start();
    set_reg(13, 8'h3A); set_reg(14, 8'h0F);
    run_op(3'b010, 5'd13, 5'd14, 5'd15, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [2:0] want;
    set_reg(9, 8'h91); set_reg(10, 8'h23);
    v = 8'h91;
    start = 1'b1; op = 3'b000; rs1 = 5'd9; rs2 = 5'd10; rd = 5'd9;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      want = {c % 5 == 0, c % 5 != 0, c % 5 == 4};
      checks++;
      if ({done, busy, rb_write} !== want) begin
        failures++;
        $display("FAIL b2b_cycle%0d done/busy/wr got=%b,%b,%b want=%b", c, done, busy, rb_write, want);
      end
      if (c == 15) start = 1'b0;
    end
    for (int k = 0; k < 3; k++) v = 8'((int'(v) + 8'h23) % 256);
    mdl[9] = v;
    checks++;
    if ({bank[9], result} !== {v, v}) begin
      failures++;
      $display("FAIL b2b_accum r9=%h res=%h want %h", bank[9], result, v);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_stop busy=%b done=%b want 0,0", busy, done);
    end
  endtask

  task automatic test_reset_in_wb();
    set_reg(11, 8'h3C); set_reg(12, 8'h01);
    start = 1'b1; op = 3'b011; rs1 = 5'd11; rs2 = 5'd12; rd = 5'd12;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rb_write, rb_sel} !== {1'b1, 5'd12}) begin
      failures++;
      $display("FAIL rst_wb_pre wr=%b sel=%0d want 1,12", rb_write, rb_sel);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rb_sel, rb_wdata, rb_write, busy, done, result, flag_z, flag_c} !== 32'd0) begin
      failures++;
      $display("FAIL rst_wb_async sel=%0d wdata=%h wr=%b busy=%b done=%b res=%h want all 0",
               rb_sel, rb_wdata, rb_write, busy, done, result);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bank[12], done} !== {8'h01, 1'b0}) begin
      failures++;
      $display("FAIL rst_wb_nowrite r12=%h done=%b want 01,0", bank[12], done);
    end
    rst_n = 1'b1;
    run_op(3'b110, 5'd11, 5'd12, 5'd16, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) set_reg(i, (i == 0) ? 8'h00 : 8'($urandom));
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_in_wb();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
